iic_req_arbiter: RTL and testbench

//  Shares one byte-level 24C02 I2C transaction engine between two requesters (e.g. key-triggered

---
 rtl/iic_req_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_iic_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_req_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one 24C02 byte-level I2C engine between two requesters.
// Define IIC_WR_CYCLE_WAIT_EN to hold off new grants for TWR_CYC cycles after a successful write.
module iic_req_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
    parameter logic [23:0] TWR_CYC     = 24'd250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  rw,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        eng_start,
    output logic        eng_abort,
    output logic        eng_rw,
    output logic [7:0]  eng_addr,
    output logic [7:0]  eng_wdata,
    input  logic        eng_done,
    input  logic        eng_nack,
    input  logic [7:0]  eng_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3
`ifdef IIC_WR_CYCLE_WAIT_EN
        , S_TWR  = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        win_s;
    logic        tmo_hit_s;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [23:0] tmo_q, tmo_d;
`ifdef IIC_WR_CYCLE_WAIT_EN
    logic [23:0] twr_q, twr_d;
    logic        twr_hit_s;
    assign twr_hit_s = (twr_q == (TWR_CYC - 24'd1));
`else
    logic        unused_twr_s;
    assign unused_twr_s = ^TWR_CYC;
`endif

    // The counter stops at the limit, so reaching it both aborts and saturates.
    assign tmo_hit_s = (tmo_q == (TIMEOUT_CYC - 24'd1));

    // Winner selection: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        win_s = 1'b0;
        case (req)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_q;
            default: win_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done || tmo_hit_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
`ifdef IIC_WR_CYCLE_WAIT_EN
                if (!rw_q && (err_q == 2'b00)) begin
                    state_d = S_TWR;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
`ifdef IIC_WR_CYCLE_WAIT_EN
            S_TWR: begin
                if (twr_hit_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TWR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; done/err/abort are registered so they coincide with DONE.
    always_comb begin
        last_d  = last_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        rdata_d = rdata_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        busy_d  = (state_d != S_IDLE);
`ifdef IIC_WR_CYCLE_WAIT_EN
        twr_d   = twr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = win_s;
                    last_d  = win_s;
                    gnt_d   = win_s ? 2'b10 : 2'b01;
                    rw_d    = win_s ? rw[1] : rw[0];
                    addr_d  = win_s ? addr[15:8] : addr[7:0];
                    wdata_d = win_s ? wdata[15:8] : wdata[7:0];
                end else begin
                    gnt_d = 2'b00;
                end
            end
            S_LAUNCH: begin
                start_d = 1'b1;
                tmo_d   = 24'd0;
            end
            S_WAIT: begin
                if (eng_done) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = eng_nack;
                    if (rw_q) begin
                        rdata_d = eng_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (tmo_hit_s) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    abort_d         = 1'b1;
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            S_DONE: begin
                gnt_d = 2'b00;
`ifdef IIC_WR_CYCLE_WAIT_EN
                twr_d = 24'd0;
`endif
            end
`ifdef IIC_WR_CYCLE_WAIT_EN
            S_TWR: begin
                twr_d = twr_q + 24'd1;
            end
`endif
            default: begin
                gnt_d = 2'b00;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            tmo_q   <= 24'd0;
`ifdef IIC_WR_CYCLE_WAIT_EN
            twr_q   <= 24'd0;
`endif
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            abort_q <= abort_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
`ifdef IIC_WR_CYCLE_WAIT_EN
            twr_q   <= twr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign eng_start = start_q;
    assign eng_abort = abort_q;
    assign eng_rw    = rw_q;
    assign eng_addr  = addr_q;
    assign eng_wdata = wdata_q;

endmodule

// File: tb/tb_iic_req_arbiter.sv
`timescale 1ns/1ps
// Bench for iic_req_arbiter: directed scenarios plus randomized two-requester traffic
// checked against a transaction-level round-robin model.
module tb_iic_req_arbiter;

    localparam logic [23:0] TMO = 24'd40;
    localparam logic [23:0] TWR = 24'd16;
`ifdef IIC_WR_CYCLE_WAIT_EN
    localparam bit TWR_EN = 1'b1;
`else
    localparam bit TWR_EN = 1'b0;
`endif
    localparam int BUDGET = 60;

    logic        clk, rst_n;
    logic [1:0]  req, rw;
    logic [15:0] addr, wdata;
    logic [1:0]  gnt, done, err;
    logic [7:0]  rdata;
    logic        busy, eng_start, eng_abort, eng_rw;
    logic [7:0]  eng_addr, eng_wdata;
    logic        eng_done, eng_nack;
    logic [7:0]  eng_rdata;

    int checks = 0;
    int errors = 0;

    bit         m_last;
    logic [7:0] m_rdata;
    bit         pend [2];
    logic       p_rw [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_wd [2];

    iic_req_arbiter #(.TIMEOUT_CYC(TMO), .TWR_CYC(TWR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_rw(eng_rw),
        .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit pick(input logic [1:0] r, input bit last);
        if (r == 2'b10) return 1'b1;
        if (r == 2'b11) return !last;
        return 1'b0;
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic reply(input int dly, input logic nack, input logic [7:0] rd);
        repeat (dly) @(negedge clk);
        eng_done = 1'b1; eng_nack = nack; eng_rdata = rd;
        @(negedge clk);
        eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
    endtask

    task automatic drive_req();
        for (int r = 0; r < 2; r++) begin
            if (pend[r]) begin
                rw[r] = p_rw[r]; addr[8*r +: 8] = p_addr[r]; wdata[8*r +: 8] = p_wd[r];
            end else begin
                rw[r] = 1'($urandom); addr[8*r +: 8] = 8'($urandom); wdata[8*r +: 8] = 8'($urandom);
            end
        end
        req = {pend[1], pend[0]};
    endtask

    task automatic new_op(input int r);
        pend[r] = 1'b1; p_rw[r] = 1'($urandom); p_addr[r] = 8'($urandom); p_wd[r] = 8'($urandom);
    endtask

    task automatic test_reset();
        checks++;
        if ({gnt, done, err, rdata, busy, eng_start, eng_abort, eng_rw, eng_addr, eng_wdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_during: outputs=%h required 0", {gnt, done, err, rdata, busy, eng_start, eng_abort, eng_rw, eng_addr, eng_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, done, err, rdata, busy, eng_start, eng_abort, eng_rw, eng_addr, eng_wdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_after: outputs=%h required 0", {gnt, done, err, rdata, busy, eng_start, eng_abort, eng_rw, eng_addr, eng_wdata});
        end
        m_last = 1'b1; m_rdata = 8'h00;
    endtask

    task automatic test_write();
        req = 2'b01; rw = 2'b00; addr = 16'h0003; wdata = 16'h00D1;
        @(negedge clk);
        checks++;
        if ({gnt, busy, eng_start} !== {2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL write_capture: gnt=%b busy=%b start=%b required 01 1 0", gnt, busy, eng_start);
        end
        @(negedge clk);
        checks++;
        if ({eng_start, eng_rw, eng_addr, eng_wdata} !== {1'b1, 1'b0, 8'h03, 8'hD1}) begin
            errors++;
            $display("FAIL write_launch: start=%b rw=%b addr=%h wdata=%h required 1 0 03 d1", eng_start, eng_rw, eng_addr, eng_wdata);
        end
        @(negedge clk);
        checks++;
        if (eng_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width: start=%b required 0", eng_start);
        end
        reply(2, 1'b0, 8'h5A);
        checks++;
        if ({done, err, gnt, rdata} !== {2'b01, 2'b00, 2'b01, m_rdata}) begin
            errors++;
            $display("FAIL write_done: done=%b err=%b gnt=%b rdata=%h required 01 00 01 %h", done, err, gnt, rdata, m_rdata);
        end
        req = 2'b00;
        m_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, gnt, busy} !== {2'b00, 2'b00, TWR_EN}) begin
            errors++;
            $display("FAIL write_release: done=%b gnt=%b busy=%b required 00 00 %b", done, gnt, busy, TWR_EN);
        end
    endtask

    task automatic test_read();
        bit ok;
        req = 2'b10; rw = 2'b10; addr = 16'h0300; wdata = 16'h0000;
        wait_start(ok);
        checks++;
        if (!ok || {gnt, eng_rw, eng_addr} !== {2'b10, 1'b1, 8'h03}) begin
            errors++;
            $display("FAIL read_launch: started=%b gnt=%b rw=%b addr=%h required 1 10 1 03", ok, gnt, eng_rw, eng_addr);
        end
        reply(3, 1'b0, 8'hD1);
        m_rdata = 8'hD1; m_last = 1'b1;
        checks++;
        if ({done, err, rdata} !== {2'b10, 2'b00, m_rdata}) begin
            errors++;
            $display("FAIL read_done: done=%b err=%b rdata=%h required 10 00 %h", done, err, rdata, m_rdata);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_ignore_done();
        @(negedge clk);
        eng_done = 1'b1; eng_nack = 1'b1; eng_rdata = 8'hEE;
        @(negedge clk);
        eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
        checks++;
        if ({done, err, busy, gnt, rdata} !== {2'b00, 2'b00, 1'b0, 2'b00, m_rdata}) begin
            errors++;
            $display("FAIL idle_eng_done: done=%b err=%b busy=%b gnt=%b rdata=%h required 00 00 0 00 %h", done, err, busy, gnt, rdata, m_rdata);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        req = 2'b01; rw = 2'b00; addr = 16'h0011; wdata = 16'h0022;
        wait_start(ok);
        n = 0;
        for (int i = 0; i < int'(TMO) + 5; i++) begin
            @(negedge clk);
            n++;
            if (done !== 2'b00) break;
        end
        checks++;
        if (!ok || n != int'(TMO)) begin
            errors++;
            $display("FAIL timeout_latency: started=%b cycles=%0d required %0d", ok, n, int'(TMO));
        end
        checks++;
        if ({done, err, eng_abort} !== {2'b01, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL timeout_abort: done=%b err=%b abort=%b required 01 01 1", done, err, eng_abort);
        end
        req = 2'b00; m_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({eng_abort, busy, gnt} !== {1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL timeout_release: abort=%b busy=%b gnt=%b required 0 0 00", eng_abort, busy, gnt);
        end
    endtask

    task automatic test_timeout_race();
        bit ok;
        req = 2'b10; rw = 2'b10; addr = 16'h4400; wdata = 16'h0000;
        wait_start(ok);
        reply(int'(TMO) - 1, 1'b0, 8'h3C);
        m_rdata = 8'h3C; m_last = 1'b1;
        checks++;
        if (!ok || {done, err, eng_abort, rdata} !== {2'b10, 2'b00, 1'b0, m_rdata}) begin
            errors++;
            $display("FAIL done_beats_timeout: started=%b done=%b err=%b abort=%b rdata=%h required 1 10 00 0 %h", ok, done, err, eng_abort, rdata, m_rdata);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_nack();
        bit ok;
        req = 2'b01; rw = 2'b00; addr = 16'h0077; wdata = 16'h0088;
        wait_start(ok);
        reply(1, 1'b1, 8'h00);
        m_last = 1'b0;
        checks++;
        if (!ok || {done, err, eng_abort} !== {2'b01, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL nack_write: started=%b done=%b err=%b abort=%b required 1 01 01 0", ok, done, err, eng_abort);
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if ({busy, gnt} !== {1'b0, 2'b00}) begin
            errors++;
            $display("FAIL nack_no_twr: busy=%b gnt=%b required 0 00", busy, gnt);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        bit w;
        logic [7:0] rd;
        @(negedge clk);
        rst_n = 1'b0; req = 2'b11; rw = 2'b11; addr = 16'($urandom); wdata = 16'($urandom);
        m_last = 1'b1; m_rdata = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(ok);
            w = pick(2'b11, m_last);
            checks++;
            if (!ok || gnt !== (w ? 2'b10 : 2'b01) || eng_addr !== (w ? addr[15:8] : addr[7:0])) begin
                errors++;
                $display("FAIL rr_grant_%0d: started=%b gnt=%b addr=%h required requester %0d", k, ok, gnt, eng_addr, w);
            end
            m_last = w;
            rd = 8'($urandom);
            reply(int'($urandom_range(0, 5)), 1'b0, rd);
            m_rdata = rd;
            checks++;
            if ({done, rdata} !== {(w ? 2'b10 : 2'b01), m_rdata}) begin
                errors++;
                $display("FAIL rr_done_%0d: done=%b rdata=%h required requester %0d rdata %h", k, done, rdata, w, m_rdata);
            end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_midtxn();
        bit ok;
        req = 2'b10; rw = 2'b10; addr = 16'h5500;
        wait_start(ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, done, eng_abort, eng_start, rdata} !== 15'd0) begin
            errors++;
            $display("FAIL reset_midtxn: gnt=%b busy=%b done=%b abort=%b start=%b rdata=%h required all 0", gnt, busy, done, eng_abort, eng_start, rdata);
        end
        m_last = 1'b1; m_rdata = 8'h00;
        req = 2'b11; rw = 2'b00; addr = 16'h2211; wdata = 16'h4433;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(ok);
        checks++;
        if (!ok || gnt !== (pick(2'b11, m_last) ? 2'b10 : 2'b01) || eng_addr !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_grant: started=%b gnt=%b addr=%h required 1 01 11", ok, gnt, eng_addr);
        end
        m_last = 1'b0;
        reply(2, 1'b1, 8'h00);
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok;
        bit w;
        logic nack;
        logic [7:0] rd;
        logic [1:0] exp_done;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) new_op(r);
            end
            if (!pend[0] && !pend[1]) new_op(0);
            drive_req();
            w = pick({pend[1], pend[0]}, m_last);
            wait_start(ok);
            checks++;
            if (!ok || {gnt, eng_rw, eng_addr, eng_wdata} !== {(w ? 2'b10 : 2'b01), p_rw[w], p_addr[w], p_wd[w]}) begin
                errors++;
                $display("FAIL rand_launch_%0d: started=%b gnt=%b rw=%b addr=%h wdata=%h required requester %0d rw=%b addr=%h wdata=%h",
                         it, ok, gnt, eng_rw, eng_addr, eng_wdata, w, p_rw[w], p_addr[w], p_wd[w]);
            end
            m_last = w;
            drive_req();
            nack = ($urandom_range(0, 3) == 0);
            rd = 8'($urandom);
            reply(int'($urandom_range(0, 6)), nack, rd);
            if (p_rw[w]) m_rdata = rd;
            exp_done = w ? 2'b10 : 2'b01;
            checks++;
            if ({done, err, rdata} !== {exp_done, (nack ? exp_done : 2'b00), m_rdata}) begin
                errors++;
                $display("FAIL rand_done_%0d: done=%b err=%b rdata=%h required %b %b %h", it, done, err, rdata, exp_done, (nack ? exp_done : 2'b00), m_rdata);
            end
            pend[w] = 1'b0;
            drive_req();
            @(negedge clk);
            checks++;
            if ({done, gnt, busy} !== {2'b00, 2'b00, (TWR_EN && !p_rw[w] && !nack)}) begin
                errors++;
                $display("FAIL rand_release_%0d: done=%b gnt=%b busy=%b required 00 00 %b", it, done, gnt, busy, (TWR_EN && !p_rw[w] && !nack));
            end
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        req = 2'b00;
        repeat (int'(TWR) + 4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; rw = 2'b00; addr = 16'h0000; wdata = 16'h0000;
        eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_ignore_done();
        test_timeout();
        test_timeout_race();
        test_nack();
        test_round_robin();
        test_reset_midtxn();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
